// File: rtl/waveform_to_pipe.sv
// rtl/waveform_to_pipe.sv - logs 32-bit samples taken on a slow tick into a 16-bit word FIFO drained by a host pipe
//
// Ports:
//   clk          host pipe clock, the only clock in this block
//   reset        synchronous active-high reset
//   sample_tick  slow sample clock, asynchronous to clk; each rising edge logs one sample
//   sample_data  32-bit value to log, stable around the sample_tick rising edge
//   enable       logging enable
//   ep_read      host read strobe; ep_datain is updated on the following edge
//   ep_datain    word to host (low half then high half of each sample)
//   ep_ready     high when at least BLOCK_LEN words are buffered
//   word_count   FIFO occupancy in words (0 .. 2^DEPTH_LOG2)
//   overflow     sticky: a sample was dropped
//   underflow    sticky: a read was made while empty

module waveform_to_pipe #(
    parameter int DEPTH_LOG2 = 10,
    parameter int BLOCK_LEN  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic [31:0]           sample_data,
    input  logic                  enable,
    input  logic                  ep_read,
    output logic [15:0]           ep_datain,
    output logic                  ep_ready,
    output logic [DEPTH_LOG2:0]   word_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   ACCEPT_MAX = (DEPTH_LOG2 + 1)'(DEPTH - 2);
    localparam logic [DEPTH_LOG2:0]   ONE_CNT    = 1;
    localparam logic [DEPTH_LOG2-1:0] ONE_PTR    = 1;
    localparam logic [31:0]           BLOCK_THR  = BLOCK_LEN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR_LO,
        S_WR_HI
    } state_t;

    logic [15:0] mem [DEPTH];

    logic                  sync1_q, sync2_q, edge_q;
    logic [1:0]            low_cnt_q;
    state_t                state_q, state_d;
    logic [31:0]           hold_q, hold_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [15:0]           dout_q, dout_d;
    logic                  ready_q;
    logic                  ovf_q, ovf_d, udf_q, udf_d;

    logic                  armed, capture, wr_en, rd_en;
    logic [15:0]           wr_word;

    // The sync flops reset to 0, so the first post-reset value of sync1_q is
    // not a real observation. Requiring three consecutive low samples means the
    // tick was genuinely seen low on two edges before any rising edge counts;
    // a tick that was already high through reset is therefore never logged.
    assign armed   = (low_cnt_q == 2'd3);
    assign capture = sync2_q & ~edge_q & armed;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        wr_en    = 1'b0;
        wr_word  = hold_q[15:0];
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        dout_d   = dout_q;
        rd_en    = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE: begin
                // Space for both halves is reserved up front so a sample is
                // either written whole or not at all.
                if (capture && enable) begin
                    if (count_q <= ACCEPT_MAX) begin
                        state_d = S_WR_LO;
                        hold_d  = sample_data;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            S_WR_LO: begin
                wr_en   = 1'b1;
                wr_word = hold_q[15:0];
                state_d = S_WR_HI;
                if (capture && enable) ovf_d = 1'b1;
            end
            S_WR_HI: begin
                wr_en   = 1'b1;
                wr_word = hold_q[31:16];
                state_d = S_IDLE;
                if (capture && enable) ovf_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (ep_read) begin
            if (count_q != '0) begin
                rd_en  = 1'b1;
                dout_d = mem[rd_ptr_q];
            end else begin
                dout_d = 16'h0000;
                udf_d  = 1'b1;
            end
        end

        if (wr_en) wr_ptr_d = wr_ptr_q + ONE_PTR;
        if (rd_en) rd_ptr_d = rd_ptr_q + ONE_PTR;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            edge_q    <= 1'b0;
            low_cnt_q <= 2'd0;
            state_q   <= S_IDLE;
            hold_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dout_q    <= 16'h0000;
            ready_q   <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            sync1_q   <= sample_tick;
            sync2_q   <= sync1_q;
            edge_q    <= sync2_q;
            if (!armed) low_cnt_q <= sync1_q ? 2'd0 : low_cnt_q + 2'd1;
            state_q   <= state_d;
            hold_q    <= hold_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            dout_q    <= dout_d;
            ready_q   <= (32'(count_q) >= BLOCK_THR);
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    // Storage carries no reset; a write in a reset cycle is suppressed so a
    // half sample can never land behind freshly cleared pointers.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem[wr_ptr_q] <= wr_word;
    end

    assign ep_datain  = dout_q;
    assign ep_ready   = ready_q;
    assign word_count = count_q;
    assign overflow   = ovf_q;
    assign underflow  = udf_q;

endmodule

// File: tb/tb_waveform_to_pipe.sv
// tb/tb_waveform_to_pipe.sv - scoreboard bench for waveform_to_pipe

module tb_waveform_to_pipe;

    localparam int DL    = 4;
    localparam int BL    = 8;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_tick;
    logic [31:0] sample_data;
    logic        enable;
    wire logic   ep_read;
    logic [15:0] ep_datain;
    logic        ep_ready;
    logic [DL:0] word_count;
    logic        overflow;
    logic        underflow;

    logic rd_manual = 1'b0;
    logic rd_rand   = 1'b0;
    logic rnd_bit   = 1'b0;
    assign ep_read = rd_rand ? rnd_bit : rd_manual;

    waveform_to_pipe #(.DEPTH_LOG2(DL), .BLOCK_LEN(BL)) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_tick(sample_tick),
        .sample_data(sample_data),
        .enable     (enable),
        .ep_read    (ep_read),
        .ep_datain  (ep_datain),
        .ep_ready   (ep_ready),
        .word_count (word_count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        int          avail;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int          ecnt     = 0;
    logic        rd_seen  = 1'b0;
    int          rd_edge  = 0;
    logic [DL:0] wc_edge  = '0;
    logic        rst_edge = 1'b1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at edge %0d", name, got, exp, ecnt);
        end
    endtask

    // Record what the DUT saw at each active edge.
    always @(posedge clk) begin
        ecnt     <= ecnt + 1;
        rd_seen  <= ep_read && !reset;
        rd_edge  <= ecnt + 1;
        wc_edge  <= word_count;
        rst_edge <= reset;
    end

    always @(negedge clk) rnd_bit = ($urandom_range(3) != 0);

    // Monitor: every read strobe produces one word; it must be the oldest
    // logged word already in the buffer, or zero if nothing was there yet.
    always @(negedge clk) begin
        chk("ep_ready", ep_ready, (!rst_edge && wc_edge >= BL));
        if (rd_seen) begin
            if (sb.size() > 0 && sb[0].avail <= rd_edge) begin
                chk("read_data", ep_datain, sb[0].w);
                sb.pop_front();
            end else begin
                chk("read_empty", ep_datain, 32'h0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A tick raised after edge n is synchronised and accepted at edge n+3;
    // the low half lands at n+4 (readable from n+5), the high half at n+5.
    task automatic do_tick(input logic [31:0] d, input int hi, input int lo);
        exp_t e;
        sample_data = d;
        if (enable && sb.size() <= DEPTH - 2) begin
            e.w = d[15:0];  e.avail = ecnt + 5; sb.push_back(e);
            e.w = d[31:16]; e.avail = ecnt + 6; sb.push_back(e);
        end
        sample_tick = 1'b1;
        step(hi);
        sample_tick = 1'b0;
        step(lo);
    endtask

    task automatic rd_burst(input int n);
        rd_manual = 1'b1;
        step(n);
        rd_manual = 1'b0;
        step(3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        sample_tick = 1'b0;
        sample_data = '0;
        enable      = 1'b0;
        step(3);
        chk("rst_datain", ep_datain, 32'h0);
        chk("rst_ready", ep_ready, 32'h0);
        chk("rst_count", word_count, 32'h0);
        chk("rst_ovf", overflow, 32'h0);
        chk("rst_udf", underflow, 32'h0);
        reset = 1'b0;
        step(6);

        do_tick(32'hDEAD_BEEF, 4, 4);
        chk("disabled_count", word_count, 32'd0);
        chk("disabled_ovf", overflow, 32'd0);

        enable = 1'b1;
        do_tick(32'h3F66_6666, 4, 4);
        chk("one_sample_count", word_count, 32'd2);
        rd_burst(2);
        chk("one_sample_drained", word_count, 32'd0);
        chk("one_sample_udf", underflow, 32'd0);

        for (int i = 1; i <= 9; i++) begin
            do_tick($urandom, 4, 4);
            if (i == 4) begin
                chk("fill4_count", word_count, 32'd8);
                chk("fill4_ready", ep_ready, 32'd1);
            end
            if (i == 5) chk("fill5_count", word_count, 32'd10);
            if (i == 8) begin
                chk("fill8_count", word_count, 32'd16);
                chk("fill8_ovf", overflow, 32'd0);
            end
            if (i == 9) begin
                chk("fill9_count", word_count, 32'd16);
                chk("fill9_ovf", overflow, 32'd1);
            end
        end

        rd_burst(17);
        chk("drain_udf", underflow, 32'd1);
        chk("drain_count", word_count, 32'd0);
        chk("drain_datain", ep_datain, 32'h0);
        chk("drain_sb_empty", sb.size(), 32'd0);

        sample_data = 32'h1234_5678;
        sample_tick = 1'b1;
        step(3);
        reset = 1'b1;
        step(1);
        reset       = 1'b0;
        sample_tick = 1'b0;
        step(6);
        chk("midrst_count", word_count, 32'd0);
        chk("midrst_ovf", overflow, 32'd0);
        chk("midrst_udf", underflow, 32'd0);
        chk("midrst_datain", ep_datain, 32'h0);
        do_tick(32'hA5A5_5A5A, 4, 4);
        chk("postrst_count", word_count, 32'd2);
        rd_burst(2);

        rd_rand = 1'b1;
        for (int i = 0; i < 24; i++)
            do_tick($urandom, $urandom_range(3, 5), $urandom_range(3, 5));
        rd_rand = 1'b0;
        step(10);
        if (sb.size() > 0) rd_burst(sb.size());
        chk("stream_sb_empty", sb.size(), 32'd0);
        chk("stream_count", word_count, 32'd0);
        chk("stream_ovf", overflow, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/waveform_to_pipe.md
WAVEFORM_TO_PIPE -- requirements
Module: waveform_to_pipe

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 10, giving a FIFO of 2^DEPTH_LOG2 16-bit words.
REQ-002 The block SHALL have parameter BLOCK_LEN, default 256, giving the number of words per host block transfer.
REQ-003 The block SHALL have port clk, input, 1, the single clock: host pipe clock, ti_clk domain.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port sample_tick, input, 1, slow simulation clock (sim_clk), asynchronous to clk.
REQ-006 The block SHALL have port sample_data, input, 32, value to log (e.g. f_rawfr_Ia), stable around sample_tick rising edge.
REQ-007 The block SHALL have port enable, input, 1, logging enable.
REQ-008 The block SHALL have port ep_read, input, 1, okBTPipeOut read strobe.
REQ-009 The block SHALL have port ep_datain, output, 16, word to host (connects to okBTPipeOut ep_datain).
REQ-010 The block SHALL have port ep_ready, output, 1, high when a full block is available.
REQ-011 The block SHALL have port word_count, output, DEPTH_LOG2+1, FIFO occupancy in words.
REQ-012 The block SHALL have port overflow, output, 1, sticky flag for a dropped sample.
REQ-013 The block SHALL have port underflow, output, 1, sticky flag for a read while empty.
REQ-014 Clock and reset are decided: one clock; reset is synchronous and active-high (ports clk and reset).

Function
REQ-015 sample_tick SHALL pass through two sync flops plus one edge flop; capture pulse = sync2 & ~edge, exactly one clk cycle per rising edge; latency 3 clk cycles from edge to pulse.
REQ-016 On the capture pulse with enable=1, sample_data SHALL be latched into a 32-bit holding register in that cycle.
REQ-017 The write FSM SHALL have states IDLE, WR_LO and WR_HI, with these transitions:
  - IDLE->WR_LO on an accepted capture;
  - WR_LO writes hold[15:0], then ->WR_HI;
  - WR_HI writes hold[31:16], then ->IDLE.
REQ-018 A capture SHALL be accepted only in IDLE with free space >= 2 words; otherwise the whole sample is dropped, no partial write occurs, and overflow is set to 1.
REQ-019 A capture pulse arriving while the FSM is in WR_LO or WR_HI SHALL be dropped and SHALL set overflow.
REQ-020 A capture pulse with enable=0 SHALL be ignored, with no flag change.
REQ-021 Read handling SHALL be as follows:
  - on ep_read=1 with word_count>0, ep_datain SHALL load the head word on the next rising edge (valid the cycle after ep_read) and the read pointer SHALL advance;
  - on ep_read=1 with word_count=0, ep_datain SHALL load 16'h0000, underflow SHALL be set and the pointers SHALL be unchanged;
  - with ep_read=0, ep_datain SHALL hold its value.
REQ-022 A write and a read in the same cycle SHALL both take effect: word_count unchanged, and the read SHALL return the old head, never the word being written.
REQ-023 Pointers SHALL be DEPTH_LOG2 bits and wrap modulo 2^DEPTH_LOG2; word_count SHALL range 0..2^DEPTH_LOG2 and full is word_count = 2^DEPTH_LOG2.
REQ-024 ep_ready SHALL equal (word_count >= BLOCK_LEN), registered, one cycle behind word_count.
REQ-025 Word order to the host SHALL be low half then high half of each sample, with samples in capture order.

Reset
REQ-026 While reset=1 at a clk edge, the block SHALL apply:
  - read and write pointers = 0, word_count = 0;
  - FSM = IDLE, holding register = 0;
  - sync and edge flops = 0;
  - ep_datain = 16'h0000, ep_ready = 0;
  - overflow = 0, underflow = 0.
REQ-027 Reset asserted mid-write (in WR_LO or WR_HI) SHALL discard the sample, and no half sample SHALL remain after reset.
REQ-028 The first sample_tick edge after reset deassertion SHALL be captured only if sample_tick was low for at least 2 clk cycles after reset.

Verification
REQ-029 Scenario: enable=1, one tick with sample_data=32'h3F66_6666, then 2 ep_read pulses -> ep_datain 16'h6666 then 16'h3F66; word_count 2->0.
REQ-030 Scenario: DEPTH_LOG2=4, BLOCK_LEN=8, 4 ticks -> ep_ready rises the cycle after word_count=8; 5th tick -> word_count 10.
REQ-031 Scenario: DEPTH_LOG2=4, 9 ticks with no reads -> word_count=16 after the 8th tick; 9th tick dropped; overflow=1; word_count stays 16.
REQ-032 Scenario: ep_read on an empty FIFO -> ep_datain=16'h0000; underflow=1; word_count=0.
REQ-033 Scenario: continuous ep_read while ticks arrive, with simultaneous write and read in one cycle -> no data loss or duplication; sequence matches the captured values across a pointer wrap (write >32 words with DEPTH_LOG2=4).
REQ-034 Scenario: reset pulsed one cycle after a capture (FSM in WR_LO) -> word_count=0, overflow=0, ep_datain=16'h0000; the next tick logs normally.
